// File: rtl/bti_sram_ctrl.sv
// bti_sram_ctrl: BTI request port bridged to a single-port SRAM with an in-order response FIFO
module bti_sram_ctrl #(
  parameter int BTI_AW = 32,
  parameter int BTI_DW = 32,
  parameter int TIDW = 4,
  parameter int MEM_AW = 15,
  parameter logic [31:0] BASE = 32'h0,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_vld,
  output logic                req_rdy,
  input  logic [TIDW-1:0]     req_tid,
  input  logic [BTI_AW-1:0]   req_addr,
  input  logic                req_wr,
  input  logic [BTI_DW-1:0]   req_wdata,
  input  logic [BTI_DW/8-1:0] req_strb,
  output logic                rsp_vld,
  input  logic                rsp_rdy,
  output logic [TIDW-1:0]     rsp_tid,
  output logic [BTI_DW-1:0]   rsp_data,
  output logic                rsp_ok,
  output logic                mem_cs,
  output logic                mem_we,
  output logic [BTI_DW/8-1:0] mem_wstrb,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [BTI_DW-1:0]   mem_wdata,
  input  logic [BTI_DW-1:0]   mem_rdata
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [BTI_AW-1:0] off;
  logic              in_range, acc, push, pop;
  logic              pend_vld, pend_wr, pend_err;
  logic [TIDW-1:0]   pend_tid;
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     fifo_cnt;
  logic [CW:0]       occ;
  logic [TIDW-1:0]   q_tid [DEPTH];
  logic [BTI_DW-1:0] q_data [DEPTH];
  logic              q_ok [DEPTH];
  assign rsp_vld  = fifo_cnt != '0;
  assign rsp_tid  = q_tid[rptr];
  assign rsp_data = q_data[rptr];
  assign rsp_ok   = q_ok[rptr];
  // decode, admission (pending stage counts as occupied) and SRAM drive
  always_comb begin
    off = req_addr - BTI_AW'(BASE);
    in_range = (off >> (MEM_AW+2)) == '0 && off[1:0] == 2'b00;
    occ = {1'b0, fifo_cnt} + {{CW{1'b0}}, pend_vld};
    req_rdy = !rst && occ < (CW+1)'(DEPTH);
    acc = req_vld && req_rdy;
    mem_cs = acc && in_range;
    mem_we = mem_cs && req_wr;
    mem_wstrb = mem_we ? req_strb : '0;
    mem_addr = off[MEM_AW+1:2];
    mem_wdata = req_wdata;
    push = pend_vld;
    pop = rsp_vld && rsp_rdy;
  end
  // pending stage: remembers the access issued this cycle until SRAM data returns
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend_vld <= 1'b0;
      pend_tid <= '0;
      pend_wr  <= 1'b0;
      pend_err <= 1'b0;
    end else begin
      pend_vld <= acc;
      pend_tid <= req_tid;
      pend_wr  <= req_wr;
      pend_err <= !in_range;
    end
  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
    end else begin
      wptr     <= push ? (wptr == PW'(DEPTH-1) ? '0 : wptr + PW'(1)) : wptr;
      rptr     <= pop ? (rptr == PW'(DEPTH-1) ? '0 : rptr + PW'(1)) : rptr;
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  // FIFO storage: writes and errors return zero data
  always_ff @(posedge clk)
    if (push) begin
      q_tid[wptr]  <= pend_tid;
      q_data[wptr] <= (pend_wr || pend_err) ? '0 : mem_rdata;
      q_ok[wptr]   <= !pend_err;
    end
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_cnt == CW'(DEPTH)));
endmodule

// File: tb/tb_bti_sram_ctrl.sv
// tb_bti_sram_ctrl: directed and randomized checks of bti_sram_ctrl against constants and a queue model
module tb_bti_sram_ctrl;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int MW = 15;
  typedef struct {logic [3:0] tid; logic [31:0] data; logic ok; int cyc;} rsp_t;
  logic clk = 0, rst = 1;
  logic req_vld = 0, req_wr = 0, rsp_rdy = 0;
  logic [3:0] req_tid = 0, req_strb = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic rdy4, rv4, ro4, cs4, we4;
  logic [3:0] rt4, ws4;
  logic [31:0] rd4, mw4, mr4;
  logic [14:0] ma4;
  logic rdy3, rv3, ro3, cs3, we3;
  logic [3:0] rt3, ws3;
  logic [31:0] rd3, mw3, mr3;
  logic [14:0] ma3;
  int n_chk = 0, n_pass = 0, tcyc = 0;
  logic [36:0] got4[$], got3[$];
  int cyc3[$];
  rsp_t exp_q[$];
  logic [31:0] ref_mem [int];
  logic [31:0] mem4 [1<<MW];
  logic [31:0] mem3 [1<<MW];

  always #5 clk = ~clk;

  bti_sram_ctrl #(.BASE(BASE), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(rdy4), .req_tid(req_tid), .req_addr(req_addr),
    .req_wr(req_wr), .req_wdata(req_wdata), .req_strb(req_strb), .rsp_vld(rv4), .rsp_rdy(rsp_rdy),
    .rsp_tid(rt4), .rsp_data(rd4), .rsp_ok(ro4), .mem_cs(cs4), .mem_we(we4), .mem_wstrb(ws4),
    .mem_addr(ma4), .mem_wdata(mw4), .mem_rdata(mr4));

  bti_sram_ctrl #(.BASE(BASE), .DEPTH(3)) u3 (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(rdy3), .req_tid(req_tid), .req_addr(req_addr),
    .req_wr(req_wr), .req_wdata(req_wdata), .req_strb(req_strb), .rsp_vld(rv3), .rsp_rdy(rsp_rdy),
    .rsp_tid(rt3), .rsp_data(rd3), .rsp_ok(ro3), .mem_cs(cs3), .mem_we(we3), .mem_wstrb(ws3),
    .mem_addr(ma3), .mem_wdata(mw3), .mem_rdata(mr3));

  function automatic logic [31:0] pat(int w);
    return (w * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b+:8] = n[8*b+:8];
    return o;
  endfunction

  initial for (int i = 0; i < (1<<MW); i++) begin mem4[i] = pat(i); mem3[i] = pat(i); end

  always @(posedge clk) begin
    if (cs4) begin
      if (we4) mem4[ma4] <= merge(mem4[ma4], mw4, ws4);
      mr4 <= mem4[ma4];
    end
    if (cs3) begin
      if (we3) mem3[ma3] <= merge(mem3[ma3], mw3, ws3);
      mr3 <= mem3[ma3];
    end
  end

  task automatic drive(logic v, logic [3:0] t, logic [31:0] a, logic w, logic [31:0] d, logic [3:0] s);
    req_vld = v; req_tid = t; req_addr = a; req_wr = w; req_wdata = d; req_strb = s;
  endtask

  task automatic sample;
    @(negedge clk);
    if (rv4 && rsp_rdy) got4.push_back({rt4, rd4, ro4});
    if (rv3 && rsp_rdy) begin got3.push_back({rt3, rd3, ro3}); cyc3.push_back(tcyc); end
  endtask

  task automatic next;
    @(posedge clk); #1; tcyc++;
  endtask

  task automatic do_reset;
    rst = 1; drive(0, 0, 0, 0, 0, 0);
    next; next;
    rst = 0;
    got4.delete(); got3.delete(); cyc3.delete(); exp_q.delete();
  endtask

  task automatic test_reset;
    rst = 1; rsp_rdy = 1; drive(1, 1, BASE, 1, 32'h1234, 4'hF);
    sample;
    n_chk++; if (rdy4 !== 1'b0) $display("FAIL reset_rdy got=%b exp=0", rdy4); else n_pass++;
    n_chk++; if (rv4 !== 1'b0) $display("FAIL reset_rsp_vld got=%b exp=0", rv4); else n_pass++;
    n_chk++; if ({cs4, we4, ws4} !== 6'b0) $display("FAIL reset_mem got cs=%b we=%b strb=%h exp 0", cs4, we4, ws4); else n_pass++;
    next;
    drive(0, 0, 0, 0, 0, 0); rst = 0;
    sample;
    n_chk++; if (rdy4 !== 1'b1) $display("FAIL reset_release_rdy got=%b exp=1", rdy4); else n_pass++;
    next;
  endtask

  task automatic test_write_read;
    rsp_rdy = 1;
    drive(1, 3, BASE + 32'h10, 1, 32'hDEADBEEF, 4'hF);
    sample;
    n_chk++; if ({cs4, we4, ma4, ws4, mw4} !== {1'b1, 1'b1, 15'd4, 4'hF, 32'hDEADBEEF})
      $display("FAIL wr_mem got cs=%b we=%b addr=%0d strb=%h data=%h exp 1 1 4 f deadbeef", cs4, we4, ma4, ws4, mw4); else n_pass++;
    next;
    drive(1, 5, BASE + 32'h10, 0, 32'h0, 4'hF);
    sample;
    n_chk++; if ({cs4, we4, ma4, ws4} !== {1'b1, 1'b0, 15'd4, 4'h0})
      $display("FAIL rd_mem got cs=%b we=%b addr=%0d strb=%h exp 1 0 4 0", cs4, we4, ma4, ws4); else n_pass++;
    n_chk++; if (rv4 !== 1'b0) $display("FAIL wr_early_rsp got=%b exp=0", rv4); else n_pass++;
    next;
    drive(0, 0, 0, 0, 0, 0);
    sample;
    n_chk++; if ({rv4, rt4, rd4, ro4} !== {1'b1, 4'd3, 32'h0, 1'b1})
      $display("FAIL wr_rsp got vld=%b tid=%0d data=%h ok=%b exp 1 3 0 1", rv4, rt4, rd4, ro4); else n_pass++;
    next;
    sample;
    n_chk++; if ({rv4, rt4, rd4, ro4} !== {1'b1, 4'd5, 32'hDEADBEEF, 1'b1})
      $display("FAIL rd_rsp got vld=%b tid=%0d data=%h ok=%b exp 1 5 deadbeef 1", rv4, rt4, rd4, ro4); else n_pass++;
    next;
    sample;
    n_chk++; if (rv4 !== 1'b0) $display("FAIL wr_rd_empty got=%b exp=0", rv4); else n_pass++;
    next;
  endtask

  task automatic test_byte_merge;
    got4.delete(); rsp_rdy = 1;
    drive(1, 1, BASE + 32'h20, 1, 32'hFFFFFFFF, 4'hF); sample; next;
    drive(1, 2, BASE + 32'h20, 1, 32'h11223344, 4'h5); sample;
    n_chk++; if ({ws4, mw4} !== {4'h5, 32'h11223344}) $display("FAIL merge_strb got strb=%h data=%h exp 5 11223344", ws4, mw4); else n_pass++;
    next;
    drive(1, 3, BASE + 32'h20, 1, 32'h0, 4'h0); sample;
    n_chk++; if ({cs4, we4, ws4} !== {1'b1, 1'b1, 4'h0}) $display("FAIL zero_strb_mem got cs=%b we=%b strb=%h exp 1 1 0", cs4, we4, ws4); else n_pass++;
    next;
    drive(1, 4, BASE + 32'h20, 0, 32'h0, 4'hF); sample; next;
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) begin sample; next; end
    n_chk++; if (got4.size() != 4) $display("FAIL merge_count got=%0d exp=4", got4.size()); else n_pass++;
    if (got4.size() == 4) begin
      n_chk++; if (got4[2] !== {4'd3, 32'h0, 1'b1}) $display("FAIL zero_strb_rsp got=%h exp=%h", got4[2], {4'd3, 32'h0, 1'b1}); else n_pass++;
      n_chk++; if (got4[3] !== {4'd4, 32'hFF22FF44, 1'b1}) $display("FAIL merge_data got=%h exp=%h", got4[3], {4'd4, 32'hFF22FF44, 1'b1}); else n_pass++;
    end
  endtask

  task automatic test_errors;
    got4.delete(); rsp_rdy = 1;
    drive(1, 6, BASE + (32'h4 << MW), 0, 32'h0, 4'hF); sample;
    n_chk++; if ({rdy4, cs4} !== 2'b10) $display("FAIL err_range got rdy=%b cs=%b exp 1 0", rdy4, cs4); else n_pass++;
    next;
    drive(1, 7, BASE + 32'h2, 1, 32'hAAAA5555, 4'hF); sample;
    n_chk++; if ({cs4, we4, ws4} !== 6'b0) $display("FAIL err_align got cs=%b we=%b strb=%h exp 0", cs4, we4, ws4); else n_pass++;
    next;
    drive(1, 8, BASE - 32'h4, 0, 32'h0, 4'hF); sample;
    n_chk++; if (cs4 !== 1'b0) $display("FAIL err_below got cs=%b exp=0", cs4); else n_pass++;
    next;
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) begin sample; next; end
    n_chk++; if (got4.size() != 3) $display("FAIL err_count got=%0d exp=3", got4.size()); else n_pass++;
    for (int i = 0; i < got4.size() && i < 3; i++) begin
      n_chk++; if (got4[i] !== {4'(6 + i), 32'h0, 1'b0}) $display("FAIL err_rsp%0d got=%h exp=%h", i, got4[i], {4'(6 + i), 32'h0, 1'b0}); else n_pass++;
    end
  endtask

  task automatic test_backpressure;
    int t;
    got4.delete(); rsp_rdy = 0; t = 0;
    for (int c = 0; c < 8; c++) begin
      drive(t < 6, 4'(t), BASE + 32'(4 * (32'h200 + t)), 0, 32'h0, 4'hF);
      sample;
      n_chk++; if (rdy4 !== (c < 4)) $display("FAIL bp_rdy%0d got=%b exp=%b", c, rdy4, c < 4); else n_pass++;
      if (c >= 2) begin
        n_chk++; if ({rv4, rt4, rd4, ro4} !== {1'b1, 4'd0, pat(32'h200), 1'b1})
          $display("FAIL bp_stable%0d got vld=%b tid=%0d data=%h ok=%b exp 1 0 %h 1", c, rv4, rt4, rd4, ro4, pat(32'h200)); else n_pass++;
      end
      if (rdy4 && t < 6) t++;
      next;
    end
    n_chk++; if (t != 4) $display("FAIL bp_accepted got=%0d exp=4", t); else n_pass++;
    rsp_rdy = 1;
    for (int c = 0; c < 20; c++) begin
      drive(t < 6, 4'(t), BASE + 32'(4 * (32'h200 + t)), 0, 32'h0, 4'hF);
      sample;
      if (rdy4 && t < 6) t++;
      next;
    end
    n_chk++; if (t != 6 || got4.size() != 6) $display("FAIL bp_drain got acc=%0d rsp=%0d exp 6 6", t, got4.size()); else n_pass++;
    for (int i = 0; i < got4.size() && i < 6; i++) begin
      n_chk++; if (got4[i] !== {4'(i), pat(32'h200 + i), 1'b1}) $display("FAIL bp_rsp%0d got=%h exp=%h", i, got4[i], {4'(i), pat(32'h200 + i), 1'b1}); else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    int t0;
    do_reset; rsp_rdy = 1; t0 = tcyc;
    for (int c = 0; c < 16; c++) begin
      drive(1, 4'(c), BASE + 32'(4 * (32'h300 + c)), 0, 32'h0, 4'hF);
      sample;
      n_chk++; if (rdy3 !== 1'b1) $display("FAIL stream_rdy%0d got=%b exp=1", c, rdy3); else n_pass++;
      next;
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) begin sample; next; end
    n_chk++; if (got3.size() != 16) $display("FAIL stream_count got=%0d exp=16", got3.size()); else n_pass++;
    for (int i = 0; i < got3.size() && i < 16; i++) begin
      n_chk++; if (got3[i] !== {4'(i), pat(32'h300 + i), 1'b1} || cyc3[i] != t0 + i + 2)
        $display("FAIL stream_rsp%0d got=%h cyc=%0d exp=%h cyc=%0d", i, got3[i], cyc3[i], {4'(i), pat(32'h300 + i), 1'b1}, t0 + i + 2); else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    do_reset; rsp_rdy = 0;
    for (int c = 0; c < 3; c++) begin
      drive(1, 4'(9 + c), BASE + 32'(4 * (32'h210 + c)), 0, 32'h0, 4'hF);
      sample; next;
    end
    drive(0, 0, 0, 0, 0, 0);
    sample;
    n_chk++; if (rv4 !== 1'b1) $display("FAIL mid_queued got=%b exp=1", rv4); else n_pass++;
    rst = 1; #1;
    n_chk++; if ({rv4, rdy4} !== 2'b00) $display("FAIL mid_assert got vld=%b rdy=%b exp 0 0", rv4, rdy4); else n_pass++;
    next;
    rst = 0; rsp_rdy = 1; got4.delete();
    sample;
    n_chk++; if (rdy4 !== 1'b1) $display("FAIL mid_release_rdy got=%b exp=1", rdy4); else n_pass++;
    next;
    repeat (6) begin sample; next; end
    n_chk++; if (got4.size() != 0) $display("FAIL mid_stale got=%0d responses exp=0", got4.size()); else n_pass++;
  endtask

  task automatic test_random;
    do_reset;
    for (int c = 0; c < 400; c++) begin
      logic v, w, erdy, evld, inr, go;
      logic [3:0] t, s;
      logic [31:0] a, d, off, rd;
      int k, wi;
      rsp_t r;
      k = $urandom_range(0, 9);
      v = c < 360 && $urandom_range(0, 9) < 7;
      w = 1'($urandom_range(0, 1));
      t = 4'($urandom); s = 4'($urandom); d = $urandom;
      a = BASE + 32'(4 * (256 + $urandom_range(0, 63)));
      a = k == 0 ? BASE + (32'h4 << MW) + 32'(4 * $urandom_range(0, 3)) :
          k == 1 ? a + 32'($urandom_range(1, 3)) :
          k == 2 ? BASE - 32'(4 * $urandom_range(1, 8)) : a;
      drive(v, t, a, w, d, s);
      rsp_rdy = c >= 360 || $urandom_range(0, 9) < 7;
      sample;
      erdy = exp_q.size() < 4;
      evld = exp_q.size() > 0 && exp_q[0].cyc <= tcyc - 2;
      off = a - BASE;
      inr = off < (32'h4 << MW) && off[1:0] == 2'b00;
      go = v && erdy;
      n_chk++; if (rdy4 !== erdy) $display("FAIL rnd_rdy c=%0d got=%b exp=%b", c, rdy4, erdy); else n_pass++;
      n_chk++; if (rv4 !== evld) $display("FAIL rnd_vld c=%0d got=%b exp=%b", c, rv4, evld); else n_pass++;
      if (evld) begin
        n_chk++; if ({rt4, rd4, ro4} !== {exp_q[0].tid, exp_q[0].data, exp_q[0].ok})
          $display("FAIL rnd_rsp c=%0d got tid=%0d data=%h ok=%b exp %0d %h %b", c, rt4, rd4, ro4, exp_q[0].tid, exp_q[0].data, exp_q[0].ok); else n_pass++;
      end
      n_chk++; if (cs4 !== (go && inr)) $display("FAIL rnd_cs c=%0d got=%b exp=%b", c, cs4, go && inr); else n_pass++;
      if (go && inr) begin
        n_chk++; if ({ma4, ws4} !== {off[16:2], w ? s : 4'h0})
          $display("FAIL rnd_mem c=%0d got addr=%h strb=%h exp %h %h", c, ma4, ws4, off[16:2], w ? s : 4'h0); else n_pass++;
      end
      if (evld && rsp_rdy) void'(exp_q.pop_front());
      if (go) begin
        wi = int'(off >> 2);
        rd = 32'h0;
        if (inr) rd = ref_mem.exists(wi) ? ref_mem[wi] : pat(wi);
        if (inr && w) ref_mem[wi] = merge(rd, d, s);
        r.tid = t; r.data = (inr && !w) ? rd : 32'h0; r.ok = inr; r.cyc = tcyc;
        exp_q.push_back(r);
      end
      next;
    end
    n_chk++; if (rv4 !== 1'b0) $display("FAIL rnd_drained got=%b exp=0", rv4); else n_pass++;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_write_read;
    test_byte_merge;
    test_errors;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bti_sram_ctrl.md
BTI_SRAM_CTRL -- requirements
Module: bti_sram_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- BTI_AW, 32: request address width.
- BTI_DW, 32: data width, a multiple of 8.
- TIDW, 4: transaction id width.
- MEM_AW, 15: SRAM word-address width.
- BASE, 32'h0: byte base address of the window.
- DEPTH, 4: response FIFO entries, minimum 2.
REQ-002 Clocking SHALL be one clock; reset SHALL be asynchronous and active-high.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: async active-high reset.
- req_vld, in, 1: request valid.
- req_rdy, out, 1: request ready.
- req_tid, in, TIDW: transaction id.
- req_addr, in, BTI_AW: byte address.
- req_wr, in, 1: 1=write, 0=read.
- req_wdata, in, BTI_DW: write data.
- req_strb, in, BTI_DW/8: byte enables.
- rsp_vld, out, 1: response valid.
- rsp_rdy, in, 1: response ready.
- rsp_tid, out, TIDW: echoed id.
- rsp_data, out, BTI_DW: read data.
- rsp_ok, out, 1: 1=success, 0=error.
- mem_cs, out, 1: SRAM select.
- mem_we, out, 1: SRAM write.
- mem_wstrb, out, BTI_DW/8: SRAM byte enables.
- mem_addr, out, MEM_AW: SRAM word address.
- mem_wdata, out, BTI_DW: SRAM write data.
- mem_rdata, in, BTI_DW: SRAM read data, valid the cycle after a read select.

Function
REQ-004 A request SHALL be accepted in cycle T iff req_vld & req_rdy.
REQ-005 req_rdy SHALL be 1 iff (fifo_cnt + pend_vld) < DEPTH.
- pend_vld is the 1-entry stage holding the access issued last cycle.
- req_rdy SHALL NOT depend combinationally on req_vld or rsp_rdy.
REQ-006 The byte offset SHALL be off = req_addr - BASE, computed modulo 2^BTI_AW.
REQ-007 A request SHALL be in range iff off < (4 << MEM_AW) and off[1:0] == 0; otherwise it is an error.
REQ-008 An in-range accepted request SHALL drive, combinationally in cycle T:
- mem_cs=1, mem_we=req_wr, mem_addr=off[MEM_AW+1:2];
- mem_wdata=req_wdata, mem_wstrb=(req_wr ? req_strb : 0).
REQ-009 mem_cs SHALL be 0 for error requests and in every cycle without acceptance.
REQ-010 At end of cycle T, pend_vld SHALL be set to 1 and SHALL capture tid, wr and err.
- If no request is accepted in T, pend_vld SHALL be set to 0.
REQ-011 In cycle T+1, the pending entry SHALL be written into the FIFO:
- rsp_data = (wr | err) ? 0 : mem_rdata;
- rsp_ok = !err;
- rsp_tid = captured tid.
REQ-012 Earliest rsp_vld SHALL be cycle T+2; responses SHALL return in acceptance order.
REQ-013 rsp_vld SHALL equal (fifo_cnt != 0); rsp_* SHALL show the head entry.
REQ-014 The head entry SHALL pop when rsp_vld & rsp_rdy.
REQ-015 While rsp_vld & !rsp_rdy, rsp_tid, rsp_data and rsp_ok SHALL hold stable.
REQ-016 FIFO pointers SHALL wrap from DEPTH-1 to 0.
- fifo_cnt is $clog2(DEPTH+1) bits wide.
- Simultaneous push and pop SHALL leave fifo_cnt unchanged.
REQ-017 With DEPTH >= 3 and rsp_rdy held at 1, throughput SHALL be one request per cycle.
REQ-018 A write with req_strb == 0 SHALL assert mem_cs with zero strobes and return rsp_ok=1.
REQ-019 Overflow SHALL be impossible by construction; an assertion SHALL flag a push when fifo_cnt == DEPTH.

Reset
REQ-020 While rst=1:
- req_rdy=0, rsp_vld=0, mem_cs=0, mem_we=0, mem_wstrb=0;
- pend_vld=0, FIFO pointers=0, fifo_cnt=0.
REQ-021 Reset mid-operation SHALL discard all pending and queued responses; no stale response SHALL appear after rst falls.
REQ-022 req_rdy SHALL rise in the first cycle after rst deasserts.

Verification
REQ-023 Write then read: write addr=BASE+0x10, data=0xDEADBEEF, strb=0xF, tid=3; then read the same address with tid=5.
- Expected: mem_addr=4.
- Expected: rsp (tid3, data 0, ok1) followed by (tid5, 0xDEADBEEF, ok1).
REQ-024 Byte merge: write 0x11223344 with strb=0x5 over 0xFFFFFFFF, then read back.
- Expected read data: 0xFF22FF44.
REQ-025 Errors: requests at addr=BASE+(4<<MEM_AW) and at BASE+0x2.
- Expected: mem_cs=0 in both cycles.
- Expected: rsp_ok=0, rsp_data=0.
REQ-026 Backpressure with DEPTH=4: rsp_rdy=0 while issuing 6 reads.
- Expected: exactly 4 accepted, req_rdy=0 afterwards.
- Expected: rsp_* stable while stalled.
- On release of rsp_rdy: 4 responses in order, then the remaining 2 are accepted.
REQ-027 Streaming with DEPTH=3, rsp_rdy=1: 16 back-to-back reads.
- Expected: 16 accepts in 16 consecutive cycles.
- Expected: responses in cycles T+2..T+17 with matching tids.
REQ-028 Reset with 2 queued responses and 1 pending: pulse rst.
- Expected: rsp_vld=0 immediately on assertion.
- Expected: no response emitted after release.
- Expected: req_rdy=1 in the next cycle.
